// File: rtl/sensor_cond_pkg.sv
// Shared types and limits for the alarm sensor conditioning front end.
package sensor_cond_pkg;

  // Channel count of the alarm front end; the top-level ports are sized for it.
  localparam int NUM_SENSORS = 3;

  // Legal range for the debounce confirm length.
  localparam int DEBOUNCE_MIN = 2;
  localparam int DEBOUNCE_MAX = 255;

  // Per-channel debounce state. The two CONFIRM states hold the previous
  // clean level while a change is being qualified.
  typedef enum logic [1:0] {
    IDLE_LOW     = 2'd0,
    CONFIRM_HIGH = 2'd1,
    STABLE_HIGH  = 2'd2,
    CONFIRM_LOW  = 2'd3
  } deb_state_t;

  // True when a debounce length can be built by the channel logic.
  function automatic bit debounce_ok(input int cycles);
    return (cycles >= DEBOUNCE_MIN) && (cycles <= DEBOUNCE_MAX);
  endfunction

endpackage

// File: rtl/sensor_debounce_ch.sv
// One conditioning channel: two-flop synchronizer, confirm FSM with a
// consecutive-sample counter, and registered clean level / edge strobes.
//
// Handshake note: there is no valid/ready flow here. The raw line is a free-
// running level, and rise/fall are one-cycle strobes that are never stalled.
module sensor_debounce_ch
  import sensor_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // Terminal value: reaching it with one more agreeing sample completes the
  // DEBOUNCE_CYCLES-long run (the first sample is counted on CONFIRM entry).
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic             s0;
  logic             s1;
  deb_state_t       state;
  deb_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             enter_high;
  logic             enter_low;

  // Two-flop synchronizer; only s1 is ever looked at by the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      s0 <= raw;
      s1 <= s0;
    end
  end

  // Next-state and counter logic. The terminal compare happens before the
  // increment, so the counter never wraps; any disagreeing sample aborts the
  // change with no partial credit kept.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_high = 1'b0;
    enter_low  = 1'b0;
    case (state)
      IDLE_LOW: begin
        if (s1) begin
          state_nxt = CONFIRM_HIGH;
          cnt_nxt   = CNT_ONE;
        end
      end
      CONFIRM_HIGH: begin
        if (!s1) begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt == CNT_LAST) begin
          state_nxt  = STABLE_HIGH;
          cnt_nxt    = CNT_ZERO;
          enter_high = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        if (!s1) begin
          state_nxt = CONFIRM_LOW;
          cnt_nxt   = CNT_ONE;
        end
      end
      CONFIRM_LOW: begin
        if (s1) begin
          state_nxt = STABLE_HIGH;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = CNT_ZERO;
          enter_low = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE_LOW;
        cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE_LOW;
      cnt   <= CNT_ZERO;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Registered outputs: clean follows completed transitions only, and the
  // strobes mark the first cycle of each new clean level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      if (enter_high) begin
        clean <= 1'b1;
      end else if (enter_low) begin
        clean <= 1'b0;
      end
      rise <= enter_high;
      fall <= enter_low;
    end
  end

endmodule

// File: rtl/sensor_conditioner.sv
// Alarm sensor front end: one independent debounce channel per raw line.
// Bits 0/1/2 of sensor_clean feed state_machine sensor1/sensor2/sensor3.
module sensor_conditioner
  import sensor_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int NUM_SENSORS     = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SENSORS-1:0] sensor_raw,
  output logic [NUM_SENSORS-1:0] sensor_clean,
  output logic [NUM_SENSORS-1:0] sensor_rise,
  output logic [NUM_SENSORS-1:0] sensor_fall
);

  // Reject unbuildable configurations at elaboration time.
  if (!debounce_ok(DEBOUNCE_CYCLES)) begin : g_bad_debounce
    $error("sensor_conditioner: DEBOUNCE_CYCLES=%0d outside %0d..%0d",
           DEBOUNCE_CYCLES, DEBOUNCE_MIN, DEBOUNCE_MAX);
  end

  if (NUM_SENSORS != sensor_cond_pkg::NUM_SENSORS) begin : g_bad_count
    $error("sensor_conditioner: NUM_SENSORS must be %0d",
           sensor_cond_pkg::NUM_SENSORS);
  end

  // One channel per sensor line; channels share nothing but clock and reset.
  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_ch
    sensor_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .raw  (sensor_raw[i]),
      .clean(sensor_clean[i]),
      .rise (sensor_rise[i]),
      .fall (sensor_fall[i])
    );
  end

endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner: directed scenarios with fixed expected edges
// plus randomized level traffic checked against a run-length reference model.
module tb_sensor_conditioner;

  localparam int DEB = 8;
  localparam int LAT = DEB + 2;

  logic       clk;
  logic       reset;
  logic [2:0] sensor_raw;
  logic [2:0] sensor_clean;
  logic [2:0] sensor_rise;
  logic [2:0] sensor_fall;

  int total;
  int bad;

  // Reference model: synchronizer delay line plus, per channel, the length of
  // the current run of synchronized samples that disagree with the clean level.
  logic [2:0] m_s0;
  logic [2:0] m_s1;
  logic [2:0] m_clean;
  logic [2:0] m_rise;
  logic [2:0] m_fall;
  int         m_run [3];
  logic [8:0] exp_q [$];

  sensor_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .NUM_SENSORS    (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sensor_raw  (sensor_raw),
    .sensor_clean(sensor_clean),
    .sensor_rise (sensor_rise),
    .sensor_fall (sensor_fall)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, update the model for that edge, then settle.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_s0    = '0;
      m_s1    = '0;
      m_clean = '0;
      m_rise  = '0;
      m_fall  = '0;
      for (int i = 0; i < 3; i++) m_run[i] = 0;
    end else begin
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < 3; i++) begin
        if (m_s1[i] != m_clean[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_clean[i] = ~m_clean[i];
            if (m_clean[i]) m_rise[i] = 1'b1;
            else            m_fall[i] = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s1 = m_s0;
      m_s0 = sensor_raw;
    end
    exp_q.push_back({m_clean, m_rise, m_fall});
    #1;
  endtask

  // Driver: hold reset for a few edges with the given raw level, then release.
  task automatic do_reset(input logic [2:0] raw);
    sensor_raw = raw;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0] er, ec;
    sensor_raw = 3'b111;
    reset = 1'b1;
    for (int e = 0; e < 5; e++) begin
      tick();
      total++;
      if ({sensor_clean, sensor_rise, sensor_fall} !== 9'b0) begin
        bad++;
        $display("FAIL reset_hold: got clean=%b rise=%b fall=%b want 000", sensor_clean, sensor_rise, sensor_fall);
      end
    end
    reset = 1'b0;
    for (int e = 1; e <= LAT + 2; e++) begin
      tick();
      ec = (e >= LAT) ? 3'b111 : 3'b000;
      er = (e == LAT) ? 3'b111 : 3'b000;
      total++;
      if (sensor_clean !== ec || sensor_rise !== er || sensor_fall !== 3'b000) begin
        bad++;
        $display("FAIL reset_release edge %0d: got clean=%b rise=%b fall=%b want clean=%b rise=%b fall=000",
                 e, sensor_clean, sensor_rise, sensor_fall, ec, er);
      end
    end
  endtask

  task automatic test_step();
    logic [2:0] er, ec;
    do_reset(3'b000);
    repeat (4) tick();
    sensor_raw = 3'b001;
    for (int e = 1; e <= LAT + 3; e++) begin
      tick();
      ec = (e >= LAT) ? 3'b001 : 3'b000;
      er = (e == LAT) ? 3'b001 : 3'b000;
      total++;
      if (sensor_clean !== ec || sensor_rise !== er || sensor_fall !== 3'b000) begin
        bad++;
        $display("FAIL step edge %0d: got clean=%b rise=%b fall=%b want clean=%b rise=%b fall=000",
                 e, sensor_clean, sensor_rise, sensor_fall, ec, er);
      end
    end
  endtask

  // Seven-cycle pulse on ch1 must never be accepted.
  task automatic test_glitch();
    sensor_raw = 3'b011;
    for (int e = 1; e <= DEB - 1 + LAT + 4; e++) begin
      tick();
      if (e == DEB - 1) sensor_raw = 3'b001;
      total++;
      if (sensor_clean !== 3'b001 || sensor_rise !== 3'b000 || sensor_fall !== 3'b000) begin
        bad++;
        $display("FAIL glitch edge %0d: got clean=%b rise=%b fall=%b want clean=001 rise=000 fall=000",
                 e, sensor_clean, sensor_rise, sensor_fall);
      end
    end
  endtask

  // Ch2 toggles 1,0,1,0,1,0 then holds 1; edge 1 is the final 0->1 sample.
  task automatic test_bounce();
    logic [2:0] er, ec;
    for (int k = 0; k < 6; k++) begin
      sensor_raw = {~k[0], 2'b01};
      tick();
    end
    sensor_raw = 3'b101;
    for (int e = 1; e <= LAT + 3; e++) begin
      tick();
      ec = (e >= LAT) ? 3'b101 : 3'b001;
      er = (e == LAT) ? 3'b100 : 3'b000;
      total++;
      if (sensor_clean !== ec || sensor_rise !== er || sensor_fall !== 3'b000) begin
        bad++;
        $display("FAIL bounce edge %0d: got clean=%b rise=%b fall=%b want clean=%b rise=%b fall=000",
                 e, sensor_clean, sensor_rise, sensor_fall, ec, er);
      end
    end
  endtask

  // From clean=011, one raw change to 100 flips all three channels together.
  task automatic test_fall_parallel();
    logic [2:0] er, ef, ec;
    do_reset(3'b011);
    repeat (LAT + 4) tick();
    total++;
    if (sensor_clean !== 3'b011) begin
      bad++;
      $display("FAIL parallel_setup: got clean=%b want 011", sensor_clean);
    end
    sensor_raw = 3'b100;
    for (int e = 1; e <= LAT + 3; e++) begin
      tick();
      ec = (e >= LAT) ? 3'b100 : 3'b011;
      er = (e == LAT) ? 3'b100 : 3'b000;
      ef = (e == LAT) ? 3'b011 : 3'b000;
      total++;
      if (sensor_clean !== ec || sensor_rise !== er || sensor_fall !== ef) begin
        bad++;
        $display("FAIL parallel edge %0d: got clean=%b rise=%b fall=%b want clean=%b rise=%b fall=%b",
                 e, sensor_clean, sensor_rise, sensor_fall, ec, er, ef);
      end
    end
  endtask

  // Reset while ch0 is part-way through confirming (cnt=5 after edge 7).
  task automatic test_reset_mid();
    logic [2:0] er, ec;
    do_reset(3'b000);
    repeat (4) tick();
    sensor_raw = 3'b001;
    repeat (7) tick();
    reset = 1'b1;
    for (int e = 0; e < 6; e++) begin
      tick();
      total++;
      if ({sensor_clean, sensor_rise, sensor_fall} !== 9'b0) begin
        bad++;
        $display("FAIL reset_mid_hold: got clean=%b rise=%b fall=%b want 000", sensor_clean, sensor_rise, sensor_fall);
      end
    end
    reset = 1'b0;
    for (int e = 1; e <= LAT + 3; e++) begin
      tick();
      ec = (e >= LAT) ? 3'b001 : 3'b000;
      er = (e == LAT) ? 3'b001 : 3'b000;
      total++;
      if (sensor_clean !== ec || sensor_rise !== er || sensor_fall !== 3'b000) begin
        bad++;
        $display("FAIL reset_mid_release edge %0d: got clean=%b rise=%b fall=%b want clean=%b rise=%b fall=000",
                 e, sensor_clean, sensor_rise, sensor_fall, ec, er);
      end
    end
  endtask

  // Random hold lengths straddling the debounce length, scored against the model.
  task automatic test_random();
    int hold [3];
    logic [8:0] exp;
    do_reset(3'b000);
    exp_q.delete();
    for (int i = 0; i < 3; i++) hold[i] = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (hold[i] == 0) begin
          sensor_raw[i] = 1'($urandom_range(0, 1));
          hold[i] = $urandom_range(1, 2 * DEB);
        end
        hold[i]--;
      end
      tick();
      exp = exp_q.pop_front();
      total++;
      if ({sensor_clean, sensor_rise, sensor_fall} !== exp) begin
        bad++;
        $display("FAIL random cycle %0d: got clean=%b rise=%b fall=%b want clean=%b rise=%b fall=%b",
                 n, sensor_clean, sensor_rise, sensor_fall, exp[8:6], exp[5:3], exp[2:0]);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    sensor_raw = 3'b000;
    m_s0 = '0;
    m_s1 = '0;
    m_clean = '0;
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < 3; i++) m_run[i] = 0;
    test_reset();
    test_step();
    test_glitch();
    test_bounce();
    test_fall_parallel();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
